// File: rtl/cu_wb_if.sv
// Bundle between CU_EX/issue logic (master) and the writeback stage (slave).
interface cu_wb_if #(
  parameter int XLEN = 32
);
  logic            issue_fire;
  logic [5:0]      issue_instr;
  logic [4:0]      issue_rd;
  logic [XLEN-1:0] issue_pc;
  logic [XLEN-1:0] issue_imm;
  logic [XLEN-1:0] result_data;
  logic            result_ready;
  logic            overflow_flag;
  logic            zero_flag;
  logic            condition_met_flag;
  logic            error_flag;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            ovf_sticky;
  logic            tag_full;
  logic            tag_empty;
  logic            seq_err;
  logic [XLEN-1:0] retire_count;

  modport master (
    output issue_fire, issue_instr, issue_rd, issue_pc, issue_imm,
           result_data, result_ready, overflow_flag, zero_flag,
           condition_met_flag, error_flag,
    input  rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc,
           trap_valid, trap_pc, ovf_sticky, tag_full, tag_empty,
           seq_err, retire_count
  );

  modport slave (
    input  issue_fire, issue_instr, issue_rd, issue_pc, issue_imm,
           result_data, result_ready, overflow_flag, zero_flag,
           condition_met_flag, error_flag,
    output rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc,
           trap_valid, trap_pc, ovf_sticky, tag_full, tag_empty,
           seq_err, retire_count
  );
endinterface

// File: rtl/cu_wb.sv
// Writeback/retire stage: in-order tag FIFO popped on each result_ready rising
// edge; issues register writes, branch redirects and error traps.
module cu_wb #(
  parameter int TAG_DEPTH = 4,
  parameter int XLEN      = 32
) (
  input  logic     soc_clk,
  input  logic     WB_reset,
  cu_wb_if.slave   bus
);
  localparam int            PW      = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(TAG_DEPTH);

  logic [5:0]      instr_mem [TAG_DEPTH];
  logic [4:0]      rd_mem    [TAG_DEPTH];
  logic [XLEN-1:0] pc_mem    [TAG_DEPTH];
  logic [XLEN-1:0] imm_mem   [TAG_DEPTH];

  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic            ready_q;
  logic            seq_err_q, seq_err_d, ovf_q, ovf_d;
  logic [XLEN-1:0] retire_q, retire_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            redir_v_q, redir_v_d, trap_v_q, trap_v_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d, trap_pc_q, trap_pc_d;

  logic            full, empty, consume, retire, is_alu, is_br;
  logic            trap, alu_ret, taken, flush, push;
  logic [5:0]      head_instr;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_pc, head_imm;
  logic            zero_unused;

  assign zero_unused = bus.zero_flag;

  assign full       = (cnt_q == DEPTH_C);
  assign empty      = (cnt_q == '0);
  assign head_instr = instr_mem[rptr_q];
  assign head_rd    = rd_mem[rptr_q];
  assign head_pc    = pc_mem[rptr_q];
  assign head_imm   = imm_mem[rptr_q];

  assign consume = bus.result_ready & ~ready_q;
  assign retire  = consume & ~empty;
  assign is_alu  = (head_instr >= 6'd27) && (head_instr <= 6'd36);
  assign is_br   = (head_instr >= 6'd4)  && (head_instr <= 6'd9);
  assign trap    = retire & bus.error_flag;
  assign alu_ret = retire & ~bus.error_flag & is_alu;
  assign taken   = retire & ~bus.error_flag & is_br & bus.condition_met_flag;
  assign flush   = trap | taken;
  // a full FIFO still accepts a push when the same edge retires the head
  assign push    = bus.issue_fire & ~flush & (~full | retire);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q;
    seq_err_d  = seq_err_q;
    ovf_d      = ovf_q;
    retire_d   = retire_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    redir_v_d  = 1'b0;
    redir_pc_d = redir_pc_q;
    trap_v_d   = 1'b0;
    trap_pc_d  = trap_pc_q;

    if ((consume & empty) | (bus.issue_fire & full & ~retire)) seq_err_d = 1'b1;
    if (retire) retire_d = retire_q + XLEN'(1);
    if (alu_ret) begin
      rf_we_d    = (head_rd != 5'd0);
      rf_waddr_d = head_rd;
      rf_wdata_d = bus.result_data;
      ovf_d      = ovf_q | bus.overflow_flag;
    end
    if (trap) begin
      trap_v_d  = 1'b1;
      trap_pc_d = head_pc;
    end
    if (taken) begin
      redir_v_d  = 1'b1;
      redir_pc_d = head_pc + head_imm;
    end

    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push)   wptr_d = wptr_q + PW'(1);
      if (retire) rptr_d = rptr_q + PW'(1);
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(retire);
    end
  end

  always_ff @(posedge soc_clk) begin
    if (WB_reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      seq_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      retire_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      redir_v_q  <= 1'b0;
      redir_pc_q <= '0;
      trap_v_q   <= 1'b0;
      trap_pc_q  <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      ready_q    <= bus.result_ready;
      seq_err_q  <= seq_err_d;
      ovf_q      <= ovf_d;
      retire_q   <= retire_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      redir_v_q  <= redir_v_d;
      redir_pc_q <= redir_pc_d;
      trap_v_q   <= trap_v_d;
      trap_pc_q  <= trap_pc_d;
    end
  end

  // tag storage needs no reset; only pointer state decides validity
  always_ff @(posedge soc_clk) begin
    if (push) begin
      instr_mem[wptr_q] <= bus.issue_instr;
      rd_mem[wptr_q]    <= bus.issue_rd;
      pc_mem[wptr_q]    <= bus.issue_pc;
      imm_mem[wptr_q]   <= bus.issue_imm;
    end
  end

  assign bus.rf_we          = rf_we_q;
  assign bus.rf_waddr       = rf_waddr_q;
  assign bus.rf_wdata       = rf_wdata_q;
  assign bus.redirect_valid = redir_v_q;
  assign bus.redirect_pc    = redir_pc_q;
  assign bus.trap_valid     = trap_v_q;
  assign bus.trap_pc        = trap_pc_q;
  assign bus.ovf_sticky     = ovf_q;
  assign bus.tag_full       = full;
  assign bus.tag_empty      = empty;
  assign bus.seq_err        = seq_err_q;
  assign bus.retire_count   = retire_q;
endmodule

// File: doc/cu_wb.md
Name: cu_wb

Overview:
- Writeback/retire stage directly downstream of CU_EX.
- Holds a small in-order tag FIFO of destination register, PC, immediate and opcode for every op CU_EX accepts.
- When CU_EX signals a result, it pops the matching tag and either writes the register file, redirects the PC for a taken branch, or raises a trap on an ALU error.
- Also keeps a retired-instruction counter.

Parameters:
- TAG_DEPTH, 4, number of in-flight tag entries; power of two, minimum 2.
- XLEN, 32, data and PC width.

Ports:
- soc_clk  in  1  system clock; all state updates on rising edge.
- WB_reset  in  1  synchronous, active-high reset.
- issue_fire  in  1  an op is captured by CU_EX on this edge (upstream valid AND EX_accept).
- issue_instr  in  6  CU_EX opcode of the issued op.
- issue_rd  in  5  destination register index.
- issue_pc  in  XLEN  PC of the issued op.
- issue_imm  in  XLEN  branch offset (sign-extended, byte units).
- result_data  in  XLEN  CU_EX result.
- result_ready  in  1  CU_EX result valid (level).
- overflow_flag  in  1  CU_EX overflow.
- zero_flag  in  1  CU_EX zero flag.
- condition_met_flag  in  1  CU_EX branch condition.
- error_flag  in  1  CU_EX error.
- rf_we  out  1  register-file write strobe, one cycle.
- rf_waddr  out  5  write address.
- rf_wdata  out  XLEN  write data.
- redirect_valid  out  1  taken-branch pulse.
- redirect_pc  out  XLEN  branch target.
- trap_valid  out  1  error trap pulse.
- trap_pc  out  XLEN  PC of the faulting op.
- ovf_sticky  out  1  any retired ALU op overflowed.
- tag_full  out  1  FIFO holds TAG_DEPTH entries.
- tag_empty  out  1  FIFO holds 0 entries.
- seq_err  out  1  sticky: push when full, or result with no tag.
- retire_count  out  XLEN  retired ops, wraps modulo 2^XLEN.

Behaviour:
- **Reset:** WB_reset sampled high clears everything:
  - All outputs to 0, except tag_empty=1.
  - FIFO pointers, counter, sticky bits and edge-detect register cleared.
  - Reset mid-operation drops all tags; a result_ready arriving afterwards with no tag sets seq_err.
- **Opcode classes:**
  - Branch: issue_instr 4..9.
  - ALU: 27..36.
  - All other opcodes: retire only (count, no write, no redirect).
- **Push:** issue_fire=1 and not full: write {instr, rd, pc, imm} at the write pointer.
  - issue_fire=1 while full: entry dropped, seq_err set, no pointer change.
- **Consume:** on a cycle where result_ready=1 and result_ready was 0 on the previous cycle (rising-edge detect; a held-high ready is consumed once).
  - Consume with FIFO empty: seq_err set, no other action.
- **Retire action, on the consume edge.** All outputs are registered, so they are visible the cycle after the consume cycle, for exactly one cycle.
  - error_flag=1: trap_valid=1, trap_pc=tag.pc, no write, no redirect.
  - Else ALU class:
    - rf_we=1 only if tag.rd≠0; rf_waddr=tag.rd; rf_wdata=result_data.
    - ovf_sticky |= overflow_flag.
  - Else branch class with condition_met_flag=1: redirect_valid=1, redirect_pc=tag.pc+tag.imm, truncated to XLEN (wraps).
  - Branch with condition_met_flag=0: nothing beyond retiring.
  - retire_count increments for every consumed tag, including traps.
- **Flush:** on trap or taken redirect, the FIFO is cleared at that same edge (younger ops are wrong-path).
  - A push in the same cycle is also discarded; it does not set seq_err.
- **Simultaneous push and consume, no flush:** both happen, occupancy unchanged; full and empty are evaluated on post-update occupancy.
  - Push while full combined with a same-edge consume is legal (the consume frees the slot first).
- **Pointers:** wrap modulo TAG_DEPTH; occupancy counter is log2(TAG_DEPTH)+1 bits.
- zero_flag is accepted but unused by this block.

Test Plan:
- **Reset:** hold WB_reset 2 cycles -> all strobes 0, tag_empty=1, retire_count=0, seq_err=0.
- **ADD writeback:** issue instr=27 rd=5 pc=0x100; result 0x0000000F ready -> one cycle later rf_we=1, waddr=5, wdata=0xF; retire_count=1; tag_empty=1.
- **rd=0 write suppressed:** instr=27 rd=0 -> rf_we stays 0, retire_count increments.
- **Taken branch with flush:** issue instr=4 pc=0x200 imm=0xFFFFFFF0, then issue instr=27 rd=3; result with condition_met=1 -> redirect_valid=1, redirect_pc=0x1F0; FIFO empty; the second op's later result sets seq_err.
  - Not-taken variant (condition_met=0) -> no redirect; second op retires normally.
- **Error trap:** instr=28 pc=0x300, error_flag=1 -> trap_valid=1, trap_pc=0x300, rf_we=0.
- **FIFO bounds:** 4 issues with no results -> tag_full=1; 5th issue -> seq_err=1.
  - Then a push and a consume in the same cycle -> occupancy stays 4.
  - result_ready held high 3 cycles -> exactly one retire.
